// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline types for the MEM stage: FSM states, exception codes and
// EX/MEM control-bit positions.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_TIMEOUT  = 2'b10
    } exc_t;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Bus watchdog for the MEM stage: counts REQ/WAIT cycles and flags the cycle in
// which the access has used its full TIMEOUT budget.
module mem_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The first REQ/WAIT cycle sees 0, so the TIMEOUT-th such cycle is the abort cycle.
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues lw/sw on a valid/ready data bus, stalls upstream until the
// response or a timeout, and registers the MEM/WB latch.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_req,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_valid,
    input  logic              dmem_ready,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_exc
);

    mem_state_t        state, state_n;
    logic [1:0]        ctrl;
    logic              live, mem_op, launch, expired, kill_q;
    logic              we_q, reg_write_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] alu_q, wdata_q;

    logic              wb_upd, wb_rw_n;
    logic [4:0]        wb_rd_n;
    logic [DATA_W-1:0] wb_data_n;
    exc_t              wb_exc_n;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (launch),
        .enable  (state != IDLE),
        .expired (expired)
    );

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        ctrl                = '0;
        ctrl[CTRL_MEMREAD]  = in_req & ~in_mem_write;
        ctrl[CTRL_MEMWRITE] = in_req & in_mem_write;
        // Gating with reset_n keeps the combinational outputs quiet while reset is held.
        live       = reset_n & in_valid & ~flush;
        mem_op     = live & (|ctrl);
        state_n    = state;
        stall      = 1'b0;
        launch     = 1'b0;
        dmem_valid = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        wb_upd     = 1'b0;
        wb_rw_n    = 1'b0;
        wb_rd_n    = rd_q;
        wb_data_n  = alu_q;
        wb_exc_n   = EXC_NONE;
        unique case (state)
            IDLE: begin
                wb_rd_n   = in_rd;
                wb_data_n = in_alu;
                if (mem_op && word_aligned(in_alu[1:0])) begin
                    launch     = 1'b1;
                    stall      = 1'b1;
                    dmem_valid = 1'b1;
                    dmem_we    = ctrl[CTRL_MEMWRITE];
                    dmem_addr  = in_alu;
                    dmem_wdata = in_wdata;
                    state_n    = dmem_ready ? WAIT : REQ;
                end else if (mem_op) begin
                    wb_upd   = 1'b1;
                    wb_exc_n = EXC_MISALIGN;
                end else if (live) begin
                    wb_upd  = 1'b1;
                    wb_rw_n = in_reg_write;
                end
            end
            REQ: begin
                if (expired) begin
                    state_n  = IDLE;
                    wb_upd   = ~(kill_q | flush);
                    wb_exc_n = EXC_TIMEOUT;
                end else begin
                    stall      = 1'b1;
                    dmem_valid = 1'b1;
                    dmem_we    = we_q;
                    dmem_addr  = alu_q;
                    dmem_wdata = wdata_q;
                    if (dmem_ready) state_n = WAIT;
                end
            end
            WAIT: begin
                // A response arriving in the expiry cycle still completes the access.
                if (dmem_rvalid) begin
                    state_n   = IDLE;
                    wb_upd    = ~(kill_q | flush);
                    wb_rw_n   = reg_write_q & ~we_q;
                    wb_data_n = we_q ? alu_q : dmem_rdata;
                end else if (expired) begin
                    state_n  = IDLE;
                    wb_upd   = ~(kill_q | flush);
                    wb_exc_n = EXC_TIMEOUT;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: the captured request and MEM/WB data registers are reset too, so outputs read 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            kill_q       <= 1'b0;
            we_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            wdata_q      <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exc       <= EXC_NONE;
        end else begin
            state    <= state_n;
            wb_valid <= wb_upd;
            if (state == IDLE) begin
                kill_q <= 1'b0;
            end else if (flush) begin
                kill_q <= 1'b1;
            end
            if (launch) begin
                we_q        <= ctrl[CTRL_MEMWRITE];
                reg_write_q <= in_reg_write;
                rd_q        <= in_rd;
                alu_q       <= in_alu;
                wdata_q     <= in_wdata;
            end
            if (wb_upd) begin
                wb_reg_write <= wb_rw_n;
                wb_rd        <= wb_rd_n;
                wb_data      <= wb_data_n;
                wb_exc       <= wb_exc_n;
            end
        end
    end

endmodule
